// File: rtl/sum_accumulator_pkg.sv
// rtl/sum_accumulator_pkg.sv - shared types and defaults for the packet sum sequencer
//
// Purpose: sequencer state encoding and the default width of the
//          saturating operand/carry counters.
// Ports:   none (package).

package sum_accumulator_pkg;

   // Operand and carry counters saturate at 2^COUNT_WIDTH-1.
   localparam int COUNT_WIDTH_DEFAULT = 8;

   // IDLE    : waiting for an operand
   // ISSUE   : one-cycle start pulse to the adder
   // CAPTURE : adder result is valid, fold it into the running total
   // DONE    : packet total presented until the consumer takes it
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - registered two-operand adder with one cycle of latency
//
// Purpose: on start, registers a+b and the carry-out; the result is
//          presented the cycle after start.
// Ports:   clock, reset (sync, active-high)
//          start    - begin an addition this cycle
//          a, b     - addends
//          sum      - (a+b) mod 2^DATA_WIDTH, valid one cycle after start
//          overflow - carry-out of the same addition
//          complete - set by the first start and held until reset

module adder #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] sum,
   output logic                  overflow,
   output logic                  complete
);

   logic [DATA_WIDTH:0] wide_sum;

   assign wide_sum = {1'b0, a} + {1'b0, b};

   always_ff @(posedge clock) begin
      if (reset) begin
         sum      <= '0;
         overflow <= 1'b0;
         complete <= 1'b0;
      end else if (start) begin
         sum      <= wide_sum[DATA_WIDTH-1:0];
         overflow <= wide_sum[DATA_WIDTH];
         complete <= 1'b1;
      end
   end

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - sequences an operand stream through an external adder
//
// Purpose: accepts operands over in_valid/in_ready, feeds (running total,
//          operand) to a 1-cycle-latency adder, folds the sum back into the
//          running total and presents the packet total with carry and
//          operand counts over result_valid/result_ready.
// Ports:   clock, reset (sync, active-high)
//          in_valid, in_data, in_last, in_ready     - operand stream
//          add_start, add_a, add_b                  - request to adder
//          add_sum, add_overflow                    - adder response
//          result_valid, result, result_carries,
//          result_count, result_ready               - packet result

module sum_accumulator
   import sum_accumulator_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic                   add_start,
   output logic [DATA_WIDTH-1:0]  add_a,
   output logic [DATA_WIDTH-1:0]  add_b,
   input  logic [DATA_WIDTH-1:0]  add_sum,
   input  logic                   add_overflow,
   output logic                   result_valid,
   output logic [DATA_WIDTH-1:0]  result,
   output logic [COUNT_WIDTH-1:0] result_carries,
   output logic [COUNT_WIDTH-1:0] result_count,
   input  logic                   result_ready
);

   state_t                 state;
   state_t                 state_next;
   logic [DATA_WIDTH-1:0]  accumulator;
   logic [DATA_WIDTH-1:0]  held_operand;
   logic                   last_flag;
   logic [COUNT_WIDTH-1:0] carries;
   logic [COUNT_WIDTH-1:0] count;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         accumulator  <= '0;
         held_operand <= '0;
         last_flag    <= 1'b0;
         carries      <= '0;
         count        <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  held_operand <= in_data;
                  last_flag    <= in_last;
               end
            end
            CAPTURE: begin
               accumulator <= add_sum;
               if (add_overflow && (carries != '1)) begin
                  carries <= carries + COUNT_WIDTH'(1);
               end
               if (count != '1) begin
                  count <= count + COUNT_WIDTH'(1);
               end
            end
            DONE: begin
               // Next packet starts from a clean total; the held operand is
               // overwritten on the next accept so it need not be cleared.
               if (result_ready) begin
                  accumulator <= '0;
                  carries     <= '0;
                  count       <= '0;
                  last_flag   <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      state_next   = state;
      in_ready     = 1'b0;
      add_start    = 1'b0;
      result_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            add_start  = 1'b1;
            state_next = CAPTURE;
         end
         CAPTURE: begin
            state_next = last_flag ? DONE : IDLE;
         end
         DONE: begin
            result_valid = 1'b1;
            if (result_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operands to the adder come straight from registers, so they are stable
   // across ISSUE and CAPTURE without extra staging.
   assign add_a = accumulator;
   assign add_b = held_operand;

   // Result fields only change in CAPTURE or on the DONE handshake, so they
   // hold steady while the consumer stalls.
   assign result         = accumulator;
   assign result_carries = carries;
   assign result_count   = count;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - scoreboard bench for the packet sum sequencer

module tb_sum_accumulator;

   localparam int DW  = 32;
   localparam int CW  = 8;
   localparam int CW2 = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic          in_valid, in_last, in_ready;
   logic [DW-1:0] in_data;
   logic          add_start, add_overflow, add_complete;
   logic [DW-1:0] add_a, add_b, add_sum;
   logic          result_valid, result_ready;
   logic [DW-1:0] result;
   logic [CW-1:0] result_carries, result_count;

   logic           b_in_valid, b_in_last, b_in_ready;
   logic [DW-1:0]  b_in_data;
   logic           b_add_start, b_add_overflow, b_add_complete;
   logic [DW-1:0]  b_add_a, b_add_b, b_add_sum;
   logic           b_result_valid, b_result_ready;
   logic [DW-1:0]  b_result;
   logic [CW2-1:0] b_result_carries, b_result_count;

   sum_accumulator #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .add_start(add_start), .add_a(add_a), .add_b(add_b),
      .add_sum(add_sum), .add_overflow(add_overflow),
      .result_valid(result_valid), .result(result),
      .result_carries(result_carries), .result_count(result_count),
      .result_ready(result_ready)
   );

   adder #(.DATA_WIDTH(DW)) u_adder (
      .clock(clock), .reset(reset), .start(add_start), .a(add_a), .b(add_b),
      .sum(add_sum), .overflow(add_overflow), .complete(add_complete)
   );

   sum_accumulator #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW2)) dut_b (
      .clock(clock), .reset(reset),
      .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last), .in_ready(b_in_ready),
      .add_start(b_add_start), .add_a(b_add_a), .add_b(b_add_b),
      .add_sum(b_add_sum), .add_overflow(b_add_overflow),
      .result_valid(b_result_valid), .result(b_result),
      .result_carries(b_result_carries), .result_count(b_result_count),
      .result_ready(b_result_ready)
   );

   adder #(.DATA_WIDTH(DW)) u_adder_b (
      .clock(clock), .reset(reset), .start(b_add_start), .a(b_add_a), .b(b_add_b),
      .sum(b_add_sum), .overflow(b_add_overflow), .complete(b_add_complete)
   );

   typedef struct {
      logic [DW-1:0] total;
      int            carries;
      int            count;
      int            vcyc;
      bit            chk_lat;
   } exp_t;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            start_count = 0;
   bit            rr_rand = 1'b0;
   exp_t          res_q[$];
   logic [63:0]   add_q[$];
   logic [DW-1:0] pkt[$];

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      #1;
      if (rr_rand) result_ready = 1'($urandom_range(1, 0));
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
   endtask

   // Reference: packet total is the plain sum modulo 2^DW; a carry is counted
   // each time the running sum crosses 2^DW; counts saturate at 2^cw-1.
   function automatic exp_t model(input logic [DW-1:0] ops[$], input int cw);
      exp_t           e;
      longint unsigned tot;
      int             car;
      int             sat;
      tot = 0;
      car = 0;
      sat = (1 << cw) - 1;
      foreach (ops[i]) begin
         tot = tot + longint'(ops[i]);
         if (tot >= 64'h1_0000_0000) begin
            car++;
            tot = tot - 64'h1_0000_0000;
         end
      end
      e.total   = tot[DW-1:0];
      e.carries = (car > sat) ? sat : car;
      e.count   = (ops.size() > sat) ? sat : ops.size();
      e.vcyc    = 0;
      e.chk_lat = 1'b0;
      return e;
   endfunction

   task automatic send_pkt(input int maxgap);
      exp_t          e;
      logic [DW-1:0] run;
      int            first_cyc;
      int            g;
      int            n;
      bit            nogap;
      e     = model(pkt, CW);
      run   = '0;
      nogap = 1'b1;
      first_cyc = 0;
      for (int i = 0; i < pkt.size(); i++) begin
         g = (i == 0 || maxgap == 0) ? 0 : $urandom_range(maxgap, 0);
         if (g != 0) nogap = 1'b0;
         repeat (g) begin @(posedge clock); #1; end
         in_valid = 1'b1;
         in_data  = pkt[i];
         in_last  = (i == pkt.size() - 1);
         n = 0;
         @(negedge clock);
         while (!in_ready && n < 300) begin
            n++;
            @(negedge clock);
         end
         if (!in_ready) begin
            fail_now("in_ready_timeout");
            in_valid = 1'b0;
            return;
         end
         if (i == 0) first_cyc = cyc;
         add_q.push_back({run, pkt[i]});
         run = run + pkt[i];
         if (i == pkt.size() - 1) begin
            e.vcyc    = first_cyc + 3 * pkt.size();
            e.chk_lat = nogap;
            res_q.push_back(e);
         end
         @(posedge clock); #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((res_q.size() != 0 || add_q.size() != 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (res_q.size() != 0 || add_q.size() != 0) fail_now("drain_timeout");
      @(posedge clock); #1;
   endtask

   // Monitor: pops adder requests and packet results as the DUT presents them.
   logic        prev_start = 1'b0;
   logic        prev_valid = 1'b0;
   logic [63:0] mon_ab;
   exp_t        mon_r;

   always @(negedge clock) begin
      if (reset) begin
         prev_start = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (add_start) begin
            start_count++;
            check("add_start_one_cycle", 64'(prev_start), 64'(0));
            if (add_q.size() == 0) begin
               fail_now("unexpected_add_start");
            end else begin
               mon_ab = add_q.pop_front();
               check("add_a", 64'(add_a), 64'(mon_ab[63:32]));
               check("add_b", 64'(add_b), 64'(mon_ab[31:0]));
            end
         end
         prev_start = add_start;
         if (result_valid) begin
            check("in_ready_while_done", 64'(in_ready), 64'(0));
            if (res_q.size() == 0) begin
               fail_now("unexpected_result");
            end else begin
               mon_r = res_q[0];
               if (!prev_valid && mon_r.chk_lat) check("result_latency", 64'(cyc), 64'(mon_r.vcyc));
               check("result", 64'(result), 64'(mon_r.total));
               check("result_carries", 64'(result_carries), 64'(mon_r.carries));
               check("result_count", 64'(result_count), 64'(mon_r.count));
               if (result_ready) void'(res_q.pop_front());
            end
         end
         prev_valid = result_valid;
      end
   end

   initial begin
      #500000;
      fail_now("watchdog");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int            n;
      int            sc;
      int            len;
      exp_t          eb;
      logic [DW-1:0] bops[$];

      in_valid = 1'b0; in_data = '0; in_last = 1'b0; result_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_result_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_add_start", 64'(add_start), 64'(0));
      check("rst_add_a", 64'(add_a), 64'(0));
      check("rst_add_b", 64'(add_b), 64'(0));
      check("rst_result_valid", 64'(result_valid), 64'(0));
      check("rst_result", 64'(result), 64'(0));
      check("rst_carries", 64'(result_carries), 64'(0));
      check("rst_count", 64'(result_count), 64'(0));
      @(posedge clock); #1;
      reset = 1'b0;

      // Basic packet with latency check
      pkt = '{32'd5, 32'd7, 32'd9};
      send_pkt(0);
      drain(500);

      // Wrap-around
      pkt = '{32'hFFFF_FFFF, 32'h0000_0002};
      send_pkt(0);
      drain(500);

      // Single operand
      sc = start_count;
      pkt = '{32'h0000_1234};
      send_pkt(0);
      drain(500);
      check("single_start_pulses", 64'(start_count - sc), 64'(1));

      // Backpressure in DONE with a waiting producer
      result_ready = 1'b0;
      pkt = '{32'd100, 32'd200};
      send_pkt(0);
      n = 0;
      @(negedge clock);
      while (!result_valid && n < 50) begin n++; @(negedge clock); end
      if (!result_valid) fail_now("bp_result_valid_timeout");
      @(posedge clock); #1;
      in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
      sc = start_count;
      repeat (10) begin
         @(negedge clock);
         check("bp_in_ready", 64'(in_ready), 64'(0));
      end
      check("bp_no_operand_consumed", 64'(start_count - sc), 64'(0));
      @(posedge clock); #1;
      result_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      drain(500);
      pkt = '{32'd4, 32'd6};
      send_pkt(0);
      drain(500);

      // Reset while in CAPTURE
      in_valid = 1'b1; in_data = 32'd10; in_last = 1'b0;
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 50) begin n++; @(negedge clock); end
      add_q.push_back({32'd0, 32'd10});
      @(posedge clock); #1;
      in_valid = 1'b0;
      n = 0;
      @(negedge clock);
      while (!add_start && n < 20) begin n++; @(negedge clock); end
      if (!add_start) fail_now("mid_reset_no_start");
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      add_q.delete();
      res_q.delete();
      check("mid_rst_in_ready", 64'(in_ready), 64'(1));
      check("mid_rst_add_start", 64'(add_start), 64'(0));
      check("mid_rst_add_a", 64'(add_a), 64'(0));
      check("mid_rst_add_b", 64'(add_b), 64'(0));
      check("mid_rst_result_valid", 64'(result_valid), 64'(0));
      check("mid_rst_result", 64'(result), 64'(0));
      check("mid_rst_carries", 64'(result_carries), 64'(0));
      check("mid_rst_count", 64'(result_count), 64'(0));
      @(posedge clock); #1;
      reset = 1'b0;
      pkt = '{32'd3};
      send_pkt(0);
      drain(500);

      // Randomized packets with random consumer stalls
      rr_rand = 1'b1;
      for (int p = 0; p < 25; p++) begin
         len = $urandom_range(6, 1);
         pkt.delete();
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(3, 0) == 0) pkt.push_back(32'hFFFF_FFF0 | 32'($urandom_range(15, 0)));
            else pkt.push_back($urandom);
         end
         send_pkt(2);
      end
      drain(3000);
      rr_rand = 1'b0;
      result_ready = 1'b1;

      // Saturating counters on a narrow-count instance
      bops = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      eb = model(bops, CW2);
      for (int i = 0; i < bops.size(); i++) begin
         b_in_valid = 1'b1; b_in_data = bops[i]; b_in_last = (i == bops.size() - 1);
         n = 0;
         @(negedge clock);
         while (!b_in_ready && n < 50) begin n++; @(negedge clock); end
         if (!b_in_ready) fail_now("sat_in_ready_timeout");
         @(posedge clock); #1;
         b_in_valid = 1'b0; b_in_last = 1'b0;
      end
      n = 0;
      @(negedge clock);
      while (!b_result_valid && n < 50) begin n++; @(negedge clock); end
      if (!b_result_valid) fail_now("sat_result_timeout");
      check("sat_result", 64'(b_result), 64'(eb.total));
      check("sat_carries", 64'(b_result_carries), 64'(eb.carries));
      check("sat_count", 64'(b_result_count), 64'(eb.count));
      @(posedge clock); #1;

      repeat (5) @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Upstream sequencer for the `adder` stage: accepts a stream of operands over a valid/ready handshake and drives the adder's start/addend ports with (running total, next operand).
- Captures the adder's sum/overflow, counts carry-outs and operands, and presents the packet total plus statistics over a valid/ready result handshake.
- Sits between an operand producer and the result consumer; owns no arithmetic itself.

Parameters:
- DATA_WIDTH, 32, width of operands, running total and adder ports
- COUNT_WIDTH, 8, width of operand counter and carry counter (both saturate)

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- in_valid  in  1  operand present
- in_data  in  DATA_WIDTH  operand value
- in_last  in  1  operand is final of packet
- in_ready  out  1  block can accept operand this cycle
- add_start  out  1  start pulse to adder
- add_a  out  DATA_WIDTH  addend1 to adder (running total)
- add_b  out  DATA_WIDTH  addend2 to adder (held operand)
- add_sum  in  DATA_WIDTH  adder sum
- add_overflow  in  1  adder carry-out
- result_valid  out  1  packet result available
- result  out  DATA_WIDTH  packet total modulo 2^DATA_WIDTH
- result_carries  out  COUNT_WIDTH  number of carry-outs in packet, saturating
- result_count  out  COUNT_WIDTH  operands in packet, saturating
- result_ready  in  1  consumer accepts result

Behaviour:
- Reset (synchronous, active-high, wins over everything incl. mid-packet): state=IDLE, accumulator=0, held operand=0, last flag=0, both counters=0; outputs: in_ready=1 the cycle after reset releases, add_start=0, add_a=0, add_b=0, result_valid=0, result=0, result_carries=0, result_count=0. Partial packet discarded.
- Adder contract: fixed 1-cycle latency; add_sum/add_overflow sampled exactly one cycle after add_start=1. The adder's complete flag is sticky and is not used.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE: in_ready=1. On in_valid: latch in_data into held operand, latch in_last, go ISSUE. No in_valid: stay.
- ISSUE: in_ready=0; add_start=1 for exactly this one cycle; add_a=accumulator, add_b=held operand (add_a/add_b registered, stable in ISSUE and CAPTURE); go CAPTURE.
- CAPTURE: add_start=0; accumulator<=add_sum; carries<=carries+add_overflow, saturating at 2^COUNT_WIDTH-1; count<=count+1, saturating; if last flag go DONE else IDLE.
- DONE: result_valid=1; result/result_carries/result_count reflect accumulator/counters and are stable while result_valid=1 && result_ready=0; in_ready=0. On result_ready: accumulator, counters, last flag cleared; go IDLE (result_valid=0 next cycle).
- Throughput: one operand per 3 cycles; packet of N operands → result_valid asserted 3N cycles after first accept edge.
- Single-operand packet (in_last on first operand): result=operand, count=1.
- Wrap-around: total modulo 2^DATA_WIDTH; each wrap increments carries.
- result_ready while not DONE: ignored. in_valid outside IDLE: not accepted, producer holds.

Decomposition:
- Shared package: state enum type (IDLE, ISSUE, CAPTURE, DONE) and the saturating-increment width constant COUNT_WIDTH default.
- No sub-module; block instantiates nothing. Top-level glue connects add_* ports to `adder`.
- The bench instantiates `adder` alongside this block.

Test Plan:
- Packet {5, 7, 9 last}, result_ready=1 → result=21, result_count=3, result_carries=0, result_valid 9 cycles after first accept.
- DATA_WIDTH=32, {0xFFFFFFFF, 0x00000002 last} → result=0x00000001, result_carries=1, result_count=2.
- Single operand 0x1234 with in_last → result=0x1234, count=1; add_start pulses exactly once, add_a=0, add_b=0x1234.
- Backpressure: result_ready=0 for 10 cycles in DONE with in_valid=1 → result fields stable, in_ready=0, no operand consumed; after result_ready, next packet starts from accumulator=0.
- Reset asserted in CAPTURE mid-packet → next cycle all outputs zero, in_ready=1; new packet {3 last} gives result=3, count=1.
- COUNT_WIDTH=2, five operands of 0xFFFFFFFF → result=0xFFFFFFFB, result_count=3 (saturated), result_carries=3 (saturated).
